// File: rtl/sk9822_pkg.sv
// Shared types and constants for the SK9822 stream decoder.
package sk9822_pkg;

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_LED  = 2'd1,
    ST_END  = 2'd2
  } sk_state_t;

  localparam int unsigned START_BITS = 32;
  localparam logic [2:0]  LED_HDR    = 3'b111;

  localparam int unsigned HDR_LSB = 29;
  localparam int unsigned BRI_LSB = 24;
  localparam int unsigned B_LSB   = 16;
  localparam int unsigned G_LSB   = 8;
  localparam int unsigned R_LSB   = 0;
  localparam int unsigned BRI_W   = 5;
  localparam int unsigned COLOR_W = 8;

endpackage

// File: rtl/sk9822_edge_sync.sv
// Two-flop synchronisers for cko/sdi and cko rising-edge strobe.
module sk9822_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic cko,
  input  logic sdi,
  output logic bit_stb,
  output logic bit_val
);

  logic r_cko_m, r_cko_s, r_cko_d;
  logic r_sdi_m, r_sdi_s;

  // sdi travels through the same depth as cko so both are sampled together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cko_m <= 1'b0;
      r_cko_s <= 1'b0;
      r_cko_d <= 1'b0;
      r_sdi_m <= 1'b0;
      r_sdi_s <= 1'b0;
    end else begin
      r_cko_m <= cko;
      r_cko_s <= r_cko_m;
      r_cko_d <= r_cko_s;
      r_sdi_m <= sdi;
      r_sdi_s <= r_sdi_m;
    end
  end

  assign bit_stb = r_cko_s & ~r_cko_d;
  assign bit_val = r_sdi_s;

endmodule

// File: rtl/sk9822_rx.sv
// SK9822 serial stream decoder: start-frame hunt, LED word decode, idle abort.
// Optional feature macro: SK9822_RX_CHKSUM_EN adds frame_sum (r+g+b per frame).
module sk9822_rx
  import sk9822_pkg::*;
#(
  parameter int NUM_LEDS    = 16,
  parameter int IDLE_CYCLES = 1500
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cko,
  input  logic                        sdi,
  output logic                        led_valid,
  output logic [$clog2(NUM_LEDS)-1:0] led_idx,
  output logic [4:0]                  led_bri,
  output logic [7:0]                  led_b,
  output logic [7:0]                  led_g,
  output logic [7:0]                  led_r,
  output logic                        frame_done,
  output logic                        err,
  output logic                        busy
`ifdef SK9822_RX_CHKSUM_EN
  ,
  output logic [15:0]                 frame_sum
`endif
);

  localparam int IDX_W  = $clog2(NUM_LEDS);
  localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);

  logic w_bit_stb, w_bit_val;

  sk9822_edge_sync u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .cko     (cko),
    .sdi     (sdi),
    .bit_stb (w_bit_stb),
    .bit_val (w_bit_val)
  );

  sk_state_t          r_state, w_state;
  logic [5:0]         r_zero_cnt, w_zero_cnt;
  logic [4:0]         r_bit_cnt, w_bit_cnt;
  logic [30:0]        r_shift, w_shift;
  logic [IDX_W-1:0]   r_idx, w_idx;
  logic [IDLE_W-1:0]  r_idle_cnt;
  logic               r_led_valid, w_led_valid;
  logic               r_frame_done, w_frame_done;
  logic               r_err, w_err;
  logic [IDX_W-1:0]   r_led_idx, w_led_idx;
  logic [BRI_W-1:0]   r_bri, w_bri;
  logic [COLOR_W-1:0] r_b, w_b, r_g, w_g, r_r, w_r;
  logic [31:0]        w_word;
  logic               w_timeout;
  logic               w_enter_led;

  // Counter resets on each cko edge; timeout fires once as it reaches saturation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_idle_cnt <= '0;
    else if (w_bit_stb)
      r_idle_cnt <= '0;
    else if (r_idle_cnt != IDLE_W'(IDLE_CYCLES))
      r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
  end

  assign w_timeout = !w_bit_stb && (r_idle_cnt == IDLE_W'(IDLE_CYCLES - 1));
  assign w_word    = {r_shift, w_bit_val};

  always_comb begin
    w_state      = r_state;
    w_zero_cnt   = r_zero_cnt;
    w_bit_cnt    = r_bit_cnt;
    w_shift      = r_shift;
    w_idx        = r_idx;
    w_led_valid  = 1'b0;
    w_frame_done = 1'b0;
    w_err        = 1'b0;
    w_enter_led  = 1'b0;
    w_led_idx    = r_led_idx;
    w_bri        = r_bri;
    w_b          = r_b;
    w_g          = r_g;
    w_r          = r_r;
    unique case (r_state)
      ST_HUNT, ST_END: begin
        if (w_bit_stb) begin
          if (w_bit_val) begin
            w_zero_cnt = '0;
          end else if (r_zero_cnt == 6'(START_BITS - 1)) begin
            w_state     = ST_LED;
            w_zero_cnt  = '0;
            w_bit_cnt   = '0;
            w_idx       = '0;
            w_enter_led = 1'b1;
          end else begin
            w_zero_cnt = r_zero_cnt + 6'd1;
          end
        end else if (w_timeout && (r_state == ST_END)) begin
          w_state = ST_HUNT;
        end
      end
      ST_LED: begin
        if (w_bit_stb) begin
          w_shift   = w_word[30:0];
          w_bit_cnt = r_bit_cnt + 5'd1;
          if (r_bit_cnt == 5'd31) begin
            if (w_word[HDR_LSB +: 3] == LED_HDR) begin
              w_led_valid = 1'b1;
              w_led_idx   = r_idx;
              w_bri       = w_word[BRI_LSB +: BRI_W];
              w_b         = w_word[B_LSB +: COLOR_W];
              w_g         = w_word[G_LSB +: COLOR_W];
              w_r         = w_word[R_LSB +: COLOR_W];
              if (r_idx == IDX_W'(NUM_LEDS - 1)) begin
                w_frame_done = 1'b1;
                w_state      = ST_END;
                w_idx        = '0;
              end else begin
                w_idx = r_idx + IDX_W'(1);
              end
            end else begin
              w_err   = 1'b1;
              w_state = ST_HUNT;
            end
          end
        end else if (w_timeout) begin
          // A stall right after the start frame has lost no data, so no error
          w_err   = (r_bit_cnt != 5'd0) || (r_idx != '0);
          w_state = ST_HUNT;
        end
      end
      default: w_state = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_HUNT;
      r_zero_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_idx        <= '0;
      r_led_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
      r_led_idx    <= '0;
      r_bri        <= '0;
      r_b          <= '0;
      r_g          <= '0;
      r_r          <= '0;
    end else begin
      r_state      <= w_state;
      r_zero_cnt   <= w_zero_cnt;
      r_bit_cnt    <= w_bit_cnt;
      r_shift      <= w_shift;
      r_idx        <= w_idx;
      r_led_valid  <= w_led_valid;
      r_frame_done <= w_frame_done;
      r_err        <= w_err;
      r_led_idx    <= w_led_idx;
      r_bri        <= w_bri;
      r_b          <= w_b;
      r_g          <= w_g;
      r_r          <= w_r;
    end
  end

  assign led_valid  = r_led_valid;
  assign frame_done = r_frame_done;
  assign err        = r_err;
  assign led_idx    = r_led_idx;
  assign led_bri    = r_bri;
  assign led_b      = r_b;
  assign led_g      = r_g;
  assign led_r      = r_r;
  assign busy       = (r_state != ST_HUNT);

`ifdef SK9822_RX_CHKSUM_EN
  logic [15:0] r_acc, r_frame_sum, w_rgb;

  assign w_rgb = 16'(w_word[R_LSB +: COLOR_W]) + 16'(w_word[G_LSB +: COLOR_W])
               + 16'(w_word[B_LSB +: COLOR_W]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_frame_sum <= '0;
    end else if (w_enter_led) begin
      r_acc       <= '0;
      r_frame_sum <= '0;
    end else if (w_led_valid) begin
      r_acc <= r_acc + w_rgb;
      if (w_frame_done)
        r_frame_sum <= r_acc + w_rgb;
    end
  end

  assign frame_sum = r_frame_sum;
`endif

endmodule

// File: tb/tb_sk9822_rx.sv
// Directed, table-driven bench for sk9822_rx (default parameters).
module tb_sk9822_rx;

  localparam int IDLE = 1500;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cko = 1'b0;
  logic        sdi = 1'b0;
  logic        led_valid;
  logic [3:0]  led_idx;
  logic [4:0]  led_bri;
  logic [7:0]  led_b, led_g, led_r;
  logic        frame_done, err, busy;
`ifdef SK9822_RX_CHKSUM_EN
  logic [15:0] frame_sum;
`endif

  sk9822_rx #(.NUM_LEDS(16), .IDLE_CYCLES(IDLE)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cko        (cko),
    .sdi        (sdi),
    .led_valid  (led_valid),
    .led_idx    (led_idx),
    .led_bri    (led_bri),
    .led_b      (led_b),
    .led_g      (led_g),
    .led_r      (led_r),
    .frame_done (frame_done),
    .err        (err),
    .busy       (busy)
`ifdef SK9822_RX_CHKSUM_EN
    ,
    .frame_sum  (frame_sum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic [4:0]  bri;
    logic [7:0]  b;
    logic [7:0]  g;
    logic [7:0]  r;
  } vec_t;

  vec_t tbl [16];

  logic [33:0] ev_q [$];
  int n_err  = 0;
  int n_done = 0;
  int n_both = 0;
  int checks = 0;
  int errors = 0;

  always @(negedge clk) begin
    if (led_valid) ev_q.push_back({led_idx, led_bri, led_b, led_g, led_r, frame_done});
    if (err) n_err++;
    if (frame_done) n_done++;
    if (err && (led_valid || frame_done)) n_both++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    sdi = b;
    #33 cko = 1'b1;
    #33 cko = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_table_frame();
    send_word(32'h0);
    for (int i = 0; i < 16; i++) send_word(tbl[i].word);
    send_word(32'hFFFF_FFFF);
  endtask

  function automatic logic [33:0] exp_ev(input int i);
    return {4'(i), tbl[i].bri, tbl[i].b, tbl[i].g, tbl[i].r, (i == 15)};
  endfunction

  function automatic logic [63:0] outs();
    return 64'({led_valid, led_idx, led_bri, led_b, led_g, led_r, frame_done, err, busy});
  endfunction

  int base, e0, d0;

  initial begin
    tbl[0]  = '{32'hE110_2030, 5'h01, 8'h10, 8'h20, 8'h30};
    tbl[1]  = '{32'hFFFF_FFFF, 5'h1F, 8'hFF, 8'hFF, 8'hFF};
    tbl[2]  = '{32'hE000_0000, 5'h00, 8'h00, 8'h00, 8'h00};
    tbl[3]  = '{32'hE0FF_0000, 5'h00, 8'hFF, 8'h00, 8'h00};
    tbl[4]  = '{32'hE000_FF00, 5'h00, 8'h00, 8'hFF, 8'h00};
    tbl[5]  = '{32'hE000_00FF, 5'h00, 8'h00, 8'h00, 8'hFF};
    tbl[6]  = '{32'hF012_3456, 5'h10, 8'h12, 8'h34, 8'h56};
    tbl[7]  = '{32'hEA55_AA01, 5'h0A, 8'h55, 8'hAA, 8'h01};
    tbl[8]  = '{32'hFE80_8080, 5'h1E, 8'h80, 8'h80, 8'h80};
    tbl[9]  = '{32'hE17F_7F7F, 5'h01, 8'h7F, 8'h7F, 8'h7F};
    tbl[10] = '{32'hEF0F_1E2D, 5'h0F, 8'h0F, 8'h1E, 8'h2D};
    tbl[11] = '{32'hE5C0_FFEE, 5'h05, 8'hC0, 8'hFF, 8'hEE};
    tbl[12] = '{32'hFB00_0001, 5'h1B, 8'h00, 8'h00, 8'h01};
    tbl[13] = '{32'hE880_0000, 5'h08, 8'h80, 8'h00, 8'h00};
    tbl[14] = '{32'hF7DE_ADBE, 5'h17, 8'hDE, 8'hAD, 8'hBE};
    tbl[15] = '{32'hE110_2030, 5'h01, 8'h10, 8'h20, 8'h30};

    // Reset state
    #53;
    chk("reset_outputs", outs(), 64'h0);
`ifdef SK9822_RX_CHKSUM_EN
    chk("reset_sum", 64'(frame_sum), 64'h0);
`endif
    rst_n = 1'b1;
    wait_clks(5);
    chk("post_reset_outputs", outs(), 64'h0);

    // Full frame from the table
    base = ev_q.size(); e0 = n_err; d0 = n_done;
    send_word(32'h0);
    wait_clks(4);
    chk("busy_after_start", 64'(busy), 64'h1);
    for (int i = 0; i < 16; i++) send_word(tbl[i].word);
    send_word(32'hFFFF_FFFF);
    wait_clks(5);
    chk("frame_valid_count", 64'(ev_q.size() - base), 64'd16);
    for (int i = 0; i < 16; i++)
      chk($sformatf("led_word_%0d", i), 64'(ev_q[base + i]), 64'(exp_ev(i)));
    chk("frame_done_count", 64'(n_done - d0), 64'd1);
    chk("frame_err_count", 64'(n_err - e0), 64'd0);
    chk("busy_in_end", 64'(busy), 64'h1);
    wait_clks(IDLE + 100);
    chk("data_hold", 64'({led_idx, led_bri, led_b, led_g, led_r}),
        64'({4'd15, tbl[15].bri, tbl[15].b, tbl[15].g, tbl[15].r}));
    chk("busy_after_idle", 64'(busy), 64'h0);

    // Bad header 3'b110 on first word
    base = ev_q.size(); e0 = n_err;
    send_word(32'h0);
    send_word(32'hDFFF_FFFF);
    wait_clks(10);
    chk("hdr110_err", 64'(n_err - e0), 64'd1);
    chk("hdr110_valid", 64'(ev_q.size() - base), 64'd0);
    chk("hdr110_busy", 64'(busy), 64'h0);

    // Fifth word with header 3'b011
    base = ev_q.size(); e0 = n_err; d0 = n_done;
    send_word(32'h0);
    for (int i = 0; i < 4; i++) send_word(32'hE110_2030);
    send_word(32'h6100_0000);
    wait_clks(10);
    chk("badhdr_busy", 64'(busy), 64'h0);
    for (int i = 0; i < 11; i++) send_word(32'hE110_2030);
    send_word(32'hFFFF_FFFF);
    wait_clks(IDLE + 100);
    chk("badhdr_valid", 64'(ev_q.size() - base), 64'd4);
    chk("badhdr_err", 64'(n_err - e0), 64'd1);
    chk("badhdr_done", 64'(n_done - d0), 64'd0);

    // Truncated LED 3 then idle, then a clean frame
    base = ev_q.size(); e0 = n_err; d0 = n_done;
    send_word(32'h0);
    for (int i = 0; i < 3; i++) send_word(tbl[i].word);
    for (int i = 31; i >= 20; i--) send_bit(tbl[3].word[i]);
    wait_clks(2000);
    chk("trunc_err", 64'(n_err - e0), 64'd1);
    chk("trunc_valid", 64'(ev_q.size() - base), 64'd3);
    chk("trunc_busy", 64'(busy), 64'h0);
    base = ev_q.size();
    send_table_frame();
    wait_clks(IDLE + 100);
    chk("recover_valid", 64'(ev_q.size() - base), 64'd16);
    chk("recover_first", 64'(ev_q[base]), 64'(exp_ev(0)));
    chk("recover_last", 64'(ev_q[base + 15]), 64'(exp_ev(15)));
    chk("recover_done", 64'(n_done - d0), 64'd1);
    chk("recover_err", 64'(n_err - e0), 64'd1);

    // Back-to-back frames
    base = ev_q.size(); e0 = n_err; d0 = n_done;
    send_table_frame();
    send_table_frame();
    wait_clks(IDLE + 100);
    chk("b2b_valid", 64'(ev_q.size() - base), 64'd32);
    chk("b2b_done", 64'(n_done - d0), 64'd2);
    chk("b2b_err", 64'(n_err - e0), 64'd0);
    chk("b2b_second_first", 64'(ev_q[base + 16]), 64'(exp_ev(0)));
    chk("b2b_second_last", 64'(ev_q[base + 31]), 64'(exp_ev(15)));

    // Reset during LED 7
    base = ev_q.size(); e0 = n_err; d0 = n_done;
    send_word(32'h0);
    for (int i = 0; i < 7; i++) send_word(tbl[i].word);
    for (int i = 31; i >= 22; i--) send_bit(tbl[7].word[i]);
    wait_clks(3);
    chk("pre_reset_valid", 64'(ev_q.size() - base), 64'd7);
    #2 rst_n = 1'b0;
    #1 chk("midreset_outputs", outs(), 64'h0);
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(3);
    base = ev_q.size();
    send_table_frame();
    wait_clks(IDLE + 100);
    chk("after_reset_valid", 64'(ev_q.size() - base), 64'd16);
    chk("after_reset_first", 64'(ev_q[base]), 64'(exp_ev(0)));
    chk("after_reset_last", 64'(ev_q[base + 15]), 64'(exp_ev(15)));
    chk("after_reset_done", 64'(n_done - d0), 64'd1);
    chk("after_reset_err", 64'(n_err - e0), 64'd0);

`ifdef SK9822_RX_CHKSUM_EN
    send_word(32'h0);
    for (int i = 0; i < 16; i++) send_word(32'hFFFF_FFFF);
    send_word(32'hFFFF_FFFF);
    wait_clks(10);
    chk("frame_sum_white", 64'(frame_sum), 64'h2FD0);
    wait_clks(IDLE + 100);
`endif

    chk("err_with_valid", 64'(n_both), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sk9822_rx.md
SK9822_RX -- requirements
Module: sk9822_rx

Interface
REQ-001 Parameter NUM_LEDS, default 16: number of LED frames decoded per SK9822 frame.
REQ-002 Parameter IDLE_CYCLES, default 1500: clk cycles with no cko rising edge that abort or close a frame.
REQ-003 clk  input  1  system clock, 150 MHz; the only clock.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 cko  input  1  SK9822 serial clock, asynchronous to clk.
REQ-006 sdi  input  1  SK9822 serial data, MSB first, valid on cko rising edge.
REQ-007 led_valid  output  1  one-clk pulse: LED word decoded.
REQ-008 led_idx  output  $clog2(NUM_LEDS)  index of decoded LED, 0 = first after start frame.
REQ-009 led_bri  output  5  global brightness field.
REQ-010 led_b, led_g, led_r  output  8 each  colour fields.
REQ-011 frame_done  output  1  one-clk pulse: NUM_LEDS-th LED decoded.
REQ-012 err  output  1  one-clk pulse: bad header or truncated LED word.
REQ-013 busy  output  1  high in LED and END states.

Function
REQ-014 cko and sdi shall each pass a 2-flop synchroniser; a bit shall be captured on the clk cycle a synchronised cko rising edge is detected; clk >= 4x cko frequency is required.
REQ-015 States: HUNT, LED, END.
REQ-016 HUNT: count consecutive captured 0 bits; a 1 clears the count; at 32 go to LED with bit count 0 and led_idx 0.
REQ-017 LED: shift 32 bits; on the 32nd bit, if bits[31:29]==3'b111 decode bri=[28:24], b=[23:16], g=[15:8], r=[7:0].
REQ-018 led_valid and all data outputs shall update on the clk after the 32nd-bit capture; data outputs hold until the next led_valid.
REQ-019 Header not 3'b111: pulse err, no led_valid, go to HUNT.
REQ-020 When led_idx==NUM_LEDS-1 decodes, frame_done shall pulse in the same cycle as led_valid, and the state shall go to END; otherwise led_idx increments.
REQ-021 END: ignore end-frame bits; 32 consecutive 0 bits go to LED (back-to-back frame); idle timeout goes to HUNT.
REQ-022 The idle counter shall reset on every cko edge and saturate at IDLE_CYCLES.
REQ-023 Idle timeout in LED with bit count > 0 or led_idx > 0: pulse err, go to HUNT; timeout in HUNT is no-op.
REQ-024 err and frame_done are mutually exclusive by construction; err and led_valid are never both high.
REQ-025 A start-frame pattern inside LED state shall be treated as data; no resync mid-frame.

Reset
REQ-026 rst_n low: state HUNT, all counters 0, all outputs 0, synchroniser flops 0.
REQ-027 Reset mid-frame discards partial data; the first valid frame after release requires a full 32-zero start frame.

Configuration
REQ-028 Macro SK9822_RX_CHKSUM_EN: when defined, add output frame_sum[15:0], the modulo-2^16 sum of r+g+b over all LEDs of a frame. frame_sum updates with frame_done and is cleared at each start frame and on reset.
REQ-029 Without SK9822_RX_CHKSUM_EN, the frame_sum port and the accumulator are absent.

Structure
REQ-030 Package sk9822_pkg holds the state enum, START_BITS=32, LED_HDR=3'b111, and field offset constants.
REQ-031 Sub-module sk9822_edge_sync holds the 2-flop synchronisers and cko rising-edge detect, with outputs bit_stb and bit_val.

Verification
REQ-032 Frame: 32 zeros, 16 words 0xE1_10_20_30, then 32 ones -> 16 led_valid, led_idx 0..15, bri 1, b 0x10, g 0x20, r 0x30; frame_done with idx 15.
REQ-033 Fifth LED word 0x61_000000 -> err pulse at word 5, only 4 led_valid, state HUNT, no frame_done.
REQ-034 cko stops after 12 bits of LED 3 for 2000 clks -> one err pulse; busy falls; the next full frame decodes cleanly.
REQ-035 Two frames back-to-back, with no idle gap between end frame and start frame -> 32 led_valid, 2 frame_done.
REQ-036 rst_n asserted mid-LED 7 -> outputs 0 immediately; the following frame decodes from idx 0.
REQ-037 With SK9822_RX_CHKSUM_EN, 16 LEDs r=g=b=0xFF -> frame_sum 0x2FD0.
